vstore_w_beat_gen: RTL and testbench

Parametrised AXI W-channel beat generator for the vector store path. It replaces the fixed single-transaction W-beat logic that follows the deshuffle stage, and sits between the deshuffle output and the AXI master W port. It buffers up to `TxnDepth` outstanding transaction descriptors and packs the byte-enabled data stream into W beats with correct `strb`, `user` and `last`. It sustains one beat per cycle across transaction boundaries.

---
 rtl/vlsu_pkg.sv | 18 +
 rtl/vlsu_desc_fifo.sv | 49 ++++
 rtl/vstore_w_beat_gen.sv | 102 ++++++++++
 tb/tb_vstore_w_beat_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared vector load/store unit definitions: descriptor types and width helpers.
package vlsu_pkg;

  localparam int unsigned DefLenWidth  = 8;
  localparam int unsigned DefUserWidth = 1;

  // W-beat burst descriptor at the default AXI4 configuration.
  typedef struct packed {
    logic [DefLenWidth-1:0]  len;
    logic [DefUserWidth-1:0] user;
  } w_beat_desc_t;

  // Pointer/occupancy width for a FIFO of the given power-of-two depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vlsu_desc_fifo.sv
// Descriptor FIFO with wrap-bit pointers; a push while full is refused even if a pop
// happens in the same cycle.
module vlsu_desc_fifo
  import vlsu_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] usage
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0] wptr_q, rptr_q;
  T               mem_q [Depth];
  logic           push_ok, pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign usage   = wptr_q - rptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vstore_w_beat_gen.sv
// AXI W-channel beat generator for the vector store path: queues burst descriptors
// and packs the deshuffled byte-enabled stream into W beats with strb/user/last.
module vstore_w_beat_gen
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned TxnDepth     = 4,
  parameter int unsigned LenWidth     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          txn_valid_i,
  output logic                          txn_ready_o,
  input  logic [LenWidth-1:0]           txn_len_i,
  input  logic [AxiUserWidth-1:0]       txn_user_i,
  input  logic                          data_valid_i,
  output logic                          data_ready_o,
  input  logic [AxiDataWidth-1:0]       data_i,
  input  logic [AxiDataWidth/8-1:0]     data_be_i,
  output logic                          axi_w_valid_o,
  input  logic                          axi_w_ready_i,
  output logic [AxiDataWidth-1:0]       axi_w_data_o,
  output logic [AxiDataWidth/8-1:0]     axi_w_strb_o,
  output logic                          axi_w_last_o,
  output logic [AxiUserWidth-1:0]       axi_w_user_o,
  output logic [$clog2(TxnDepth):0]     txn_pending_o,
  output logic                          idle_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned PtrWidth  = ptr_width(TxnDepth);

  typedef struct packed {
    logic [LenWidth-1:0]     len;
    logic [AxiUserWidth-1:0] user;
  } desc_t;

  desc_t                 push_desc, head;
  logic                  fifo_full, fifo_empty;
  logic [PtrWidth-1:0]   fifo_usage;
  logic                  txn_en_q;
  logic [LenWidth-1:0]   beat_q;
  logic                  out_valid_q;
  logic                  accept, is_last;

  assign push_desc = '{len: txn_len_i, user: txn_user_i};

  vlsu_desc_fifo #(
    .T     (desc_t),
    .Depth (TxnDepth)
  ) i_desc_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (txn_valid_i && txn_ready_o),
    .wdata (push_desc),
    .pop   (accept && is_last),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .usage (fifo_usage)
  );

  // txn_en_q keeps descriptor intake closed until the first edge after reset releases.
  assign txn_ready_o   = txn_en_q && !fifo_full;
  assign data_ready_o  = !fifo_empty && (!out_valid_q || axi_w_ready_i);
  assign accept        = data_valid_i && data_ready_o;
  assign is_last       = (beat_q == head.len);
  assign axi_w_valid_o = out_valid_q;
  assign txn_pending_o = fifo_usage;
  assign idle_o        = fifo_empty && !out_valid_q && (beat_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_en_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      txn_en_q <= 1'b1;
      if (accept) beat_q <= is_last ? '0 : beat_q + 1'b1;
    end
  end

  // Output register: a beat accepted in cycle N is presented on W in cycle N+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      axi_w_data_o <= '0;
      axi_w_strb_o <= {StrbWidth{1'b0}};
      axi_w_last_o <= 1'b0;
      axi_w_user_o <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      axi_w_data_o <= data_i;
      axi_w_strb_o <= data_be_i;
      axi_w_last_o <= is_last;
      axi_w_user_o <= head.user;
    end else if (axi_w_ready_i) begin
      out_valid_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vstore_w_beat_gen.sv
// Directed bench for vstore_w_beat_gen: stimulus pushes expected W beats into a queue,
// a negedge monitor pops and compares every W handshake.
module tb_vstore_w_beat_gen;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          txn_valid_i, txn_ready_o;
  logic [7:0]    txn_len_i;
  logic [0:0]    txn_user_i;
  logic          data_valid_i, data_ready_o;
  logic [DW-1:0] data_i;
  logic [SW-1:0] data_be_i;
  logic          axi_w_valid_o, axi_w_ready_i;
  logic [DW-1:0] axi_w_data_o;
  logic [SW-1:0] axi_w_strb_o;
  logic          axi_w_last_o;
  logic [0:0]    axi_w_user_o;
  logic [2:0]    txn_pending_o;
  logic          idle_o;

  vstore_w_beat_gen #(
    .AxiDataWidth (DW),
    .AxiUserWidth (1),
    .TxnDepth     (4),
    .LenWidth     (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .txn_valid_i   (txn_valid_i),
    .txn_ready_o   (txn_ready_o),
    .txn_len_i     (txn_len_i),
    .txn_user_i    (txn_user_i),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .data_i        (data_i),
    .data_be_i     (data_be_i),
    .axi_w_valid_o (axi_w_valid_o),
    .axi_w_ready_i (axi_w_ready_i),
    .axi_w_data_o  (axi_w_data_o),
    .axi_w_strb_o  (axi_w_strb_o),
    .axi_w_last_o  (axi_w_last_o),
    .axi_w_user_o  (axi_w_user_o),
    .txn_pending_o (txn_pending_o),
    .idle_o        (idle_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          user;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // W monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    beat_t e;
    if (axi_w_valid_o === 1'b1 && axi_w_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_w_beat", {32'd0, axi_w_data_o}, 64'hdead);
      end else begin
        e = exp_q.pop_front();
        chk("w_data", {32'd0, axi_w_data_o}, {32'd0, e.data});
        chk("w_strb", {60'd0, axi_w_strb_o}, {60'd0, e.strb});
        chk("w_last", {63'd0, axi_w_last_o}, {63'd0, e.last});
        chk("w_user", {63'd0, axi_w_user_o}, {63'd0, e.user});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic [7:0] len, input logic user);
    int n;
    n = 0;
    txn_len_i   = len;
    txn_user_i  = user;
    txn_valid_i = 1'b1;
    @(negedge clk);
    while (!txn_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!txn_ready_o) chk("txn_push_timeout", 64'd0, 64'd1);
    tick();
    txn_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] be,
                           input logic last, input logic user, output int waited);
    waited       = 0;
    data_i       = d;
    data_be_i    = be;
    data_valid_i = 1'b1;
    @(negedge clk);
    while (!data_ready_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!data_ready_o) begin
      chk("data_accept_timeout", 64'd0, 64'd1);
      tick();
      data_valid_i = 1'b0;
    end else begin
      exp_q.push_back(beat_t'{d, be, last, user});
      tick();
      data_valid_i = 1'b0;
      chk("latency_valid", {63'd0, axi_w_valid_o}, 64'd1);
      chk("latency_data", {32'd0, axi_w_data_o}, {32'd0, d});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_i = 1'b1;
    txn_valid_i = 1'b0; txn_len_i = '0; txn_user_i = '0;
    data_valid_i = 1'b0; data_i = '0; data_be_i = '0;
    axi_w_ready_i = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_w_valid", {63'd0, axi_w_valid_o}, 64'd0);
    chk("rst_txn_ready", {63'd0, txn_ready_o}, 64'd0);
    chk("rst_data_ready", {63'd0, data_ready_o}, 64'd0);
    chk("rst_pending", {61'd0, txn_pending_o}, 64'd0);
    chk("rst_idle", {63'd0, idle_o}, 64'd1);
    chk("rst_w_data", {32'd0, axi_w_data_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("txn_ready_still_low", {63'd0, txn_ready_o}, 64'd0);
    tick();
    chk("txn_ready_rises", {63'd0, txn_ready_o}, 64'd1);

    // Single burst, len=3
    axi_w_ready_i = 1'b1;
    push_txn(8'd3, 1'b0);
    @(negedge clk);
    chk("single_pending1", {61'd0, txn_pending_o}, 64'd1);
    chk("single_data_ready", {63'd0, data_ready_o}, 64'd1);
    tick();
    send_beat(32'h1111_0001, 4'hF, 1'b0, 1'b0, w);
    send_beat(32'h1111_0002, 4'hF, 1'b0, 1'b0, w);
    send_beat(32'h1111_0003, 4'hF, 1'b0, 1'b0, w);
    chk("single_pending_before_last", {61'd0, txn_pending_o}, 64'd1);
    send_beat(32'h1111_0004, 4'hF, 1'b1, 1'b0, w);
    chk("single_pending0", {61'd0, txn_pending_o}, 64'd0);
    tick();
    chk("single_idle", {63'd0, idle_o}, 64'd1);

    // Back-to-back bursts len=0 then len=1, no bubble
    push_txn(8'd0, 1'b1);
    push_txn(8'd1, 1'b0);
    send_beat(32'h0000_00A0, 4'hF, 1'b1, 1'b1, w);
    chk("b2b_wait0", 64'(w), 64'd0);
    send_beat(32'h0000_00B0, 4'hF, 1'b0, 1'b0, w);
    chk("b2b_wait1", 64'(w), 64'd0);
    send_beat(32'h0000_00C0, 4'hF, 1'b1, 1'b0, w);
    chk("b2b_wait2", 64'(w), 64'd0);
    tick();

    // FIFO full, push refused on full even with a concurrent pop
    push_txn(8'd0, 1'b0);
    push_txn(8'd0, 1'b1);
    push_txn(8'd0, 1'b0);
    push_txn(8'd0, 1'b1);
    @(negedge clk);
    chk("full_txn_ready", {63'd0, txn_ready_o}, 64'd0);
    chk("full_pending4", {61'd0, txn_pending_o}, 64'd4);
    tick();
    txn_len_i = 8'd0; txn_user_i = 1'b1; txn_valid_i = 1'b1;
    data_i = 32'hD000_0000; data_be_i = 4'hF; data_valid_i = 1'b1;
    @(negedge clk);
    chk("full_refuse_ready", {63'd0, txn_ready_o}, 64'd0);
    chk("full_pop_data_ready", {63'd0, data_ready_o}, 64'd1);
    exp_q.push_back(beat_t'{32'hD000_0000, 4'hF, 1'b1, 1'b0});
    tick();
    data_valid_i = 1'b0;
    @(negedge clk);
    chk("full_after_pop_ready", {63'd0, txn_ready_o}, 64'd1);
    chk("full_after_pop_pending", {61'd0, txn_pending_o}, 64'd3);
    tick();
    txn_valid_i = 1'b0;
    @(negedge clk);
    chk("full_fifth_accepted", {61'd0, txn_pending_o}, 64'd4);
    tick();
    send_beat(32'hD000_0001, 4'hF, 1'b1, 1'b1, w);
    send_beat(32'hD000_0002, 4'hF, 1'b1, 1'b0, w);
    send_beat(32'hD000_0003, 4'hF, 1'b1, 1'b1, w);
    send_beat(32'hD000_0004, 4'hF, 1'b1, 1'b1, w);
    tick();

    // Backpressure mid-burst
    push_txn(8'd3, 1'b0);
    send_beat(32'hE000_0001, 4'hF, 1'b0, 1'b0, w);
    axi_w_ready_i = 1'b0;
    data_i = 32'hE000_0002; data_be_i = 4'h3; data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", {32'd0, axi_w_data_o}, 64'hE000_0001);
      chk("bp_strb", {60'd0, axi_w_strb_o}, 64'hF);
      chk("bp_last", {63'd0, axi_w_last_o}, 64'd0);
      chk("bp_data_ready", {63'd0, data_ready_o}, 64'd0);
    end
    @(posedge clk);
    #1;
    axi_w_ready_i = 1'b1;
    send_beat(32'hE000_0002, 4'h3, 1'b0, 1'b0, w);
    send_beat(32'hE000_0003, 4'hF, 1'b0, 1'b0, w);
    send_beat(32'hE000_0004, 4'hF, 1'b1, 1'b0, w);
    tick();

    // Zero strobe with user=1 counts toward last
    push_txn(8'd1, 1'b1);
    send_beat(32'h5A5A_5A5A, 4'h0, 1'b0, 1'b1, w);
    send_beat(32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, w);
    tick();

    // Reset mid-burst
    push_txn(8'd3, 1'b0);
    send_beat(32'hF000_0001, 4'hF, 1'b0, 1'b0, w);
    send_beat(32'hF000_0002, 4'hF, 1'b0, 1'b0, w);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_valid", {63'd0, axi_w_valid_o}, 64'd0);
    chk("mid_rst_idle", {63'd0, idle_o}, 64'd1);
    chk("mid_rst_pending", {61'd0, txn_pending_o}, 64'd0);
    chk("mid_rst_last", {63'd0, axi_w_last_o}, 64'd0);
    chk("mid_rst_data", {32'd0, axi_w_data_o}, 64'd0);
    rst_i = 1'b0;
    tick(); tick();
    push_txn(8'd0, 1'b0);
    send_beat(32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, w);
    tick(); tick();
    chk("end_idle", {63'd0, idle_o}, 64'd1);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
